// File: rtl/fetch_redirect_pkg.sv
// Shared definitions for the fetch/redirect slice: PC width, opcode constants
// and the 2-bit branch history counter type with its saturating step.
package fetch_redirect_pkg;

  localparam int PC_W = 14;

  localparam logic [5:0] OPE_J    = 6'b000010;
  localparam logic [5:0] OPE_JAL  = 6'b000110;
  localparam logic [5:0] OPE_JR   = 6'b001000;
  localparam logic [5:0] OPE_JALR = 6'b001001;

  // Conditional branches: low opcode bits 10 with a non-zero upper pair.
  localparam logic [1:0] BR_LO_BITS  = 2'b10;
  localparam logic [1:0] BR_HI_NONE  = 2'b00;

  typedef logic [PC_W-1:0] pc_t;
  typedef logic [1:0]      ctr_t;

  localparam ctr_t CTR_INIT = 2'b01;

  function automatic logic is_jump(input logic [5:0] ope);
    return (ope == OPE_J) || (ope == OPE_JAL);
  endfunction

  function automatic logic is_cond_branch(input logic [5:0] ope);
    return (ope[1:0] == BR_LO_BITS) && (ope[5:4] != BR_HI_NONE);
  endfunction

  function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
    if (taken) begin
      return (c == 2'b11) ? c : c + 2'd1;
    end
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table: 2^IDX saturating 2-bit counters, one asynchronous read
// port, one synchronous update port, all counters reinitialised under reset.
module fetch_bht
  import fetch_redirect_pkg::*;
#(
  parameter int IDX = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [IDX-1:0] rd_idx,
  output ctr_t           rd_ctr,
  input  logic           upd_en,
  input  logic [IDX-1:0] upd_idx,
  input  logic           upd_taken
);

  localparam int DEPTH = 2 ** IDX;

  ctr_t ctr_q [DEPTH];

  // The read returns the stored value, so a same-cycle update is not visible yet.
  assign rd_ctr = ctr_q[rd_idx];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ctr
      ctr_t ctr_reg;

      always_ff @(posedge clk) begin
        if (!rstn) begin
          ctr_reg <= CTR_INIT;
        end else if (upd_en && (upd_idx == IDX'(gi))) begin
          ctr_reg <= ctr_step(ctr_reg, upd_taken);
        end
      end

      assign ctr_q[gi] = ctr_reg;
    end
  endgenerate

endmodule

// File: rtl/fetch_redirect.sv
// Fetch PC generation with hazard/jump/predicted-branch redirects and a
// one-bubble squash. Branch prediction is built only with FETCH_REDIRECT_BHT_EN.
module fetch_redirect
  import fetch_redirect_pkg::*;
#(
  parameter int BHT_IDX = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall,
  input  logic            b_is_hazard,
  input  logic [PC_W-1:0] b_addr,
  input  logic            b_is_b_ope,
  input  logic            b_is_branch,
  input  logic [PC_W-1:0] b_w_pc,
  input  logic [31:0]     inst,
  output logic [PC_W-1:0] fetch_pc,
  output logic            fetch_en,
  output logic [PC_W-1:0] pc,
  output logic            inst_valid,
  output logic            pred_taken
);

  logic [5:0] ope;
  pc_t        imm_pc;
  pc_t        fetch_pc_reg;
  pc_t        fetch_pc_next;
  pc_t        pc_reg;
  logic       valid_reg;
  logic       redirect;

  assign ope    = inst[31:26];
  assign imm_pc = inst[PC_W-1:0];

`ifdef FETCH_REDIRECT_BHT_EN
  ctr_t rd_ctr;
  logic pred_bit_reg;
  logic unused_bits;

  fetch_bht #(
    .IDX(BHT_IDX)
  ) u_bht (
    .clk      (clk),
    .rstn     (rstn),
    .rd_idx   (fetch_pc_reg[BHT_IDX-1:0]),
    .rd_ctr   (rd_ctr),
    .upd_en   (b_is_b_ope),
    .upd_idx  (b_w_pc[BHT_IDX-1:0]),
    .upd_taken(b_is_branch)
  );

  // The counter is sampled as the address is issued, so it lines up with the
  // returning instruction and naturally holds across a stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pred_bit_reg <= 1'b0;
    end else if (fetch_en) begin
      pred_bit_reg <= rd_ctr[1];
    end
  end

  assign pred_taken  = valid_reg & is_cond_branch(ope) & pred_bit_reg;
  assign unused_bits = ^{inst[25:PC_W], b_w_pc, rd_ctr[0]};
`else
  logic unused_bits;

  assign pred_taken  = 1'b0;
  assign unused_bits = ^{inst[25:PC_W], b_is_b_ope, b_is_branch, b_w_pc, 1'(BHT_IDX)};
`endif

  assign fetch_en = ~stall | b_is_hazard;

  always_comb begin
    redirect      = 1'b1;
    fetch_pc_next = fetch_pc_reg + pc_t'(1);
    if (b_is_hazard) begin
      fetch_pc_next = b_addr;
    end else if ((valid_reg && is_jump(ope)) || pred_taken) begin
      fetch_pc_next = imm_pc;
    end else begin
      redirect = 1'b0;
    end
  end

  // Any redirect squashes the fall-through address already in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc_reg <= '0;
      pc_reg       <= '0;
      valid_reg    <= 1'b0;
    end else if (fetch_en) begin
      fetch_pc_reg <= fetch_pc_next;
      pc_reg       <= fetch_pc_reg;
      valid_reg    <= ~redirect;
    end
  end

  assign fetch_pc   = fetch_pc_reg;
  assign pc         = pc_reg;
  assign inst_valid = valid_reg;

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: vector table for the main flow plus
// hand sequences for prediction, hazard priority and mid-redirect reset.
module tb_fetch_redirect;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall;
  logic        b_is_hazard;
  logic [13:0] b_addr;
  logic        b_is_b_ope;
  logic        b_is_branch;
  logic [13:0] b_w_pc;
  logic [31:0] inst;
  logic [13:0] fetch_pc;
  logic        fetch_en;
  logic [13:0] pc;
  logic        inst_valid;
  logic        pred_taken;

  logic [31:0] imem [0:16383];
  logic [13:0] iaddr_q = 14'h0;

  int checks   = 0;
  int failures = 0;

`ifdef FETCH_REDIRECT_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  always #5 clk = ~clk;

  // One-cycle-latency instruction memory.
  always @(posedge clk) if (fetch_en) iaddr_q <= fetch_pc;
  assign inst = imem[iaddr_q];

  fetch_redirect dut (
    .clk        (clk),
    .rstn       (rstn),
    .stall      (stall),
    .b_is_hazard(b_is_hazard),
    .b_addr     (b_addr),
    .b_is_b_ope (b_is_b_ope),
    .b_is_branch(b_is_branch),
    .b_w_pc     (b_w_pc),
    .inst       (inst),
    .fetch_pc   (fetch_pc),
    .fetch_en   (fetch_en),
    .pc         (pc),
    .inst_valid (inst_valid),
    .pred_taken (pred_taken)
  );

  typedef struct {
    logic        st;
    logic        hz;
    logic [13:0] ba;
    logic        bo;
    logic        bb;
    logic [13:0] bw;
    logic        exp_en;
    logic [13:0] exp_fpc;
    logic [13:0] exp_pc;
    logic        exp_v;
    logic        exp_p;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic st, input logic hz, input logic [13:0] ba,
                              input logic bo, input logic bb, input logic [13:0] bw,
                              input logic en, input logic [13:0] fpc, input logic [13:0] p,
                              input logic v, input logic pr);
    vec_t r;
    r.st = st; r.hz = hz; r.ba = ba; r.bo = bo; r.bb = bb; r.bw = bw;
    r.exp_en = en; r.exp_fpc = fpc; r.exp_pc = p; r.exp_v = v; r.exp_p = pr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic hz, input logic [13:0] ba,
                       input logic bo, input logic bb, input logic [13:0] bw);
    stall = st; b_is_hazard = hz; b_addr = ba;
    b_is_b_ope = bo; b_is_branch = bb; b_w_pc = bw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_tick();
    drive(1'b0, 1'b0, 14'h2AAA, 1'b0, 1'b1, 14'h0010);
    tick();
  endtask

  task automatic chk_state(input string tag, input logic [13:0] fpc, input logic [13:0] p,
                           input logic v, input logic pr);
    chk({tag, ".fetch_pc"}, 32'(fetch_pc), 32'(fpc));
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".valid"}, 32'(inst_valid), 32'(v));
    chk({tag, ".pred"}, 32'(pred_taken), 32'(pr));
    $display("%s: fetch_pc=%h pc=%h valid=%b pred=%b", tag, fetch_pc, pc, inst_valid, pred_taken);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) imem[i] = 32'h0;
    imem[5]     = 32'h0800_0040;  // J 0x0040
    imem[14'h10] = 32'h4800_0100; // conditional branch, target 0x0100

    // Default qualifier-off payloads are deliberately non-zero to prove they are ignored.
    tbl[0]  = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0001, 14'h0000, 1, 0);
    tbl[1]  = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0002, 14'h0001, 1, 0);
    tbl[2]  = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0003, 14'h0002, 1, 0);
    tbl[3]  = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0004, 14'h0003, 1, 0);
    tbl[4]  = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0005, 14'h0004, 1, 0);
    tbl[5]  = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0006, 14'h0005, 1, 0);
    tbl[6]  = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0040, 14'h0006, 0, 0);
    tbl[7]  = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0041, 14'h0040, 1, 0);
    tbl[8]  = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0042, 14'h0041, 1, 0);
    tbl[9]  = mk(1, 0, 14'h2AAA, 1, 1, 14'h0030, 0, 14'h0042, 14'h0041, 1, 0);
    tbl[10] = mk(1, 1, 14'h1234, 0, 0, 14'h0000, 1, 14'h1234, 14'h0042, 0, 0);
    tbl[11] = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h1235, 14'h1234, 1, 0);
    tbl[12] = mk(0, 1, 14'h3FFF, 0, 0, 14'h0000, 1, 14'h3FFF, 14'h1235, 0, 0);
    tbl[13] = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0000, 14'h3FFF, 1, 0);
    tbl[14] = mk(0, 0, 14'h2AAA, 0, 1, 14'h0010, 1, 14'h0001, 14'h0000, 1, 0);
    tbl[15] = mk(1, 0, 14'h2AAA, 0, 1, 14'h0010, 0, 14'h0001, 14'h0000, 1, 0);

    // Reset state
    rstn = 1'b0;
    drive(0, 0, 14'h0, 0, 0, 14'h0);
    repeat (3) tick();
    chk_state("reset", 14'h0000, 14'h0000, 1'b0, 1'b0);
    rstn = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].st, tbl[i].hz, tbl[i].ba, tbl[i].bo, tbl[i].bb, tbl[i].bw);
      #1;
      chk($sformatf("vec%0d.fetch_en", i), 32'(fetch_en), 32'(tbl[i].exp_en));
      tick();
      chk_state($sformatf("vec%0d", i), tbl[i].exp_fpc, tbl[i].exp_pc, tbl[i].exp_v, tbl[i].exp_p);
    end

    // Train 0x10 taken twice (01->10->11), then fetch it sequentially.
    drive(0, 1, 14'h000C, 1, 1, 14'h0010);
    tick();
    chk_state("trainA0", 14'h000C, 14'h0001, 1'b0, 1'b0);
    drive(0, 0, 14'h2AAA, 1, 1, 14'h0010);
    tick();
    chk_state("trainA1", 14'h000D, 14'h000C, 1'b1, 1'b0);
    idle_tick();
    idle_tick();
    idle_tick();
    chk_state("seqA", 14'h0010, 14'h000F, 1'b1, 1'b0);
    idle_tick();
    chk_state("predA", 14'h0011, 14'h0010, 1'b1, BHT);
    idle_tick();
    chk_state("redirA", BHT ? 14'h0100 : 14'h0012, 14'h0011, ~BHT, 1'b0);

    // Hazard in the same cycle as a predicted-taken branch: b_addr wins.
    drive(0, 1, 14'h0010, 0, 0, 14'h0000);
    tick();
    idle_tick();
    chk_state("predB", 14'h0011, 14'h0010, 1'b1, BHT);
    drive(0, 1, 14'h0200, 0, 0, 14'h0000);
    tick();
    chk_state("hazB", 14'h0200, 14'h0011, 1'b0, 1'b0);

    // Reset asserted while a redirect is pending discards it.
    drive(0, 1, 14'h0010, 0, 0, 14'h0000);
    tick();
    idle_tick();
    chk_state("predC", 14'h0011, 14'h0010, 1'b1, BHT);
    drive(0, 1, 14'h0300, 0, 0, 14'h0000);
    rstn = 1'b0;
    tick();
    chk_state("rstC", 14'h0000, 14'h0000, 1'b0, 1'b0);
    tick();
    rstn = 1'b1;

    // Counter must restart at 01: NT, NT, T -> 01, so predicted not-taken.
    drive(0, 1, 14'h000C, 1, 0, 14'h0010);
    #1;
    chk("rstC.fetch_en", 32'(fetch_en), 32'h1);
    tick();
    chk_state("postrst0", 14'h000C, 14'h0000, 1'b0, 1'b0);
    drive(0, 0, 14'h2AAA, 1, 0, 14'h0010);
    tick();
    drive(0, 0, 14'h2AAA, 1, 1, 14'h0010);
    tick();
    idle_tick();
    idle_tick();
    idle_tick();
    chk_state("predD", 14'h0011, 14'h0010, 1'b1, 1'b0);
    idle_tick();
    chk_state("noredirD", 14'h0012, 14'h0011, 1'b1, 1'b0);

    // One more taken (01->10), then a same-cycle not-taken update while 0x10
    // is read: the read sees 10, so the prediction is still taken.
    drive(0, 1, 14'h0010, 1, 1, 14'h0010);
    tick();
    drive(0, 0, 14'h2AAA, 1, 0, 14'h0010);
    tick();
    chk_state("predE", 14'h0011, 14'h0010, 1'b1, BHT);
    idle_tick();
    chk_state("redirE", BHT ? 14'h0100 : 14'h0012, 14'h0011, ~BHT, 1'b0);

    // Counter is now 01: the next visit predicts not-taken.
    drive(0, 1, 14'h0010, 0, 0, 14'h0000);
    tick();
    idle_tick();
    chk_state("predF", 14'h0011, 14'h0010, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
